tinyalu_requester: RTL

//  Initiator side of the TinyALU start/done protocol. Accepts commands on a valid/ready port and

---
 rtl/tinyalu_pkg.sv | 41 ++++
 rtl/tinyalu_req_stats.sv | 50 +++++
 rtl/tinyalu_requester.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinyalu_pkg
//  Description : Shared types for the TinyALU requester: opcodes, response
//                status codes, requester FSM states and a small opcode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tinyalu_pkg;

    localparam int OP_W     = 3;
    localparam int DATA_W   = 8;
    localparam int RESULT_W = 16;
    localparam int STATUS_W = 2;

    typedef enum logic [OP_W-1:0] {
        NO_OP = 3'd0,
        ADD   = 3'd1,
        AND   = 3'd2,
        XOR   = 3'd3,
        MUL   = 3'd4
    } op_e;

    typedef enum logic [STATUS_W-1:0] {
        OK      = 2'd0,
        TIMEOUT = 2'd1,
        ILLEGAL = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } req_state_e;

    // True for opcodes that require a start/done exchange with the ALU.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == MUL);
    endfunction

endpackage : tinyalu_pkg
`default_nettype wire

// File: rtl/tinyalu_req_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tinyalu_req_stats
//  Description : Three saturating 16-bit response counters (OK, TIMEOUT,
//                ILLEGAL), each bumped on the cycle the requester enters RESP.
//  Ports       : clk, reset_n (sync, active-low)
//                rsp_enter   - requester is entering RESP this cycle
//                rsp_status  - status being loaded on that entry
//                stat_*_cnt  - counter values
//  Revision    : 1.0  initial release
// ============================================================================
module tinyalu_req_stats
    import tinyalu_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rsp_enter,
    input  logic [STATUS_W-1:0] rsp_status,
    output logic [15:0]         stat_ok_cnt,
    output logic [15:0]         stat_tmo_cnt,
    output logic [15:0]         stat_ill_cnt
);

    localparam logic [15:0] c_SAT = 16'hFFFF;

    logic [15:0] r_ok_cnt;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_ill_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ok_cnt  <= '0;
            r_tmo_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (rsp_enter) begin
            if ((rsp_status == OK) && (r_ok_cnt != c_SAT))
                r_ok_cnt <= r_ok_cnt + 16'd1;
            if ((rsp_status == TIMEOUT) && (r_tmo_cnt != c_SAT))
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            if ((rsp_status == ILLEGAL) && (r_ill_cnt != c_SAT))
                r_ill_cnt <= r_ill_cnt + 16'd1;
        end
    end

    assign stat_ok_cnt  = r_ok_cnt;
    assign stat_tmo_cnt = r_tmo_cnt;
    assign stat_ill_cnt = r_ill_cnt;

endmodule : tinyalu_req_stats
`default_nettype wire

// File: rtl/tinyalu_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tinyalu_requester
//  Description : Initiator side of the TinyALU start/done protocol. Takes one
//                command at a time on a valid/ready port, drives the ALU,
//                waits for done (or times out) and returns result + status on
//                a valid/ready response port.
//  Ports       : clk, reset_n (sync, active-low)
//                cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b   - command in
//                alu_start/alu_op/alu_a/alu_b             - to TinyALU
//                alu_done/alu_result                      - from TinyALU
//                rsp_valid/rsp_ready/rsp_result/rsp_status - response out
//                stat_ok/tmo/ill_cnt (only with TINYALU_REQ_STATS_EN)
//  Config      : `define TINYALU_REQ_STATS_EN adds response counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tinyalu_requester
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DRAIN_CYCLES   = 3
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic                alu_start,
    output logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic                alu_done,
    input  logic [RESULT_W-1:0] alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_result,
    output logic [STATUS_W-1:0] rsp_status
`ifdef TINYALU_REQ_STATS_EN
    ,
    output logic [15:0]         stat_ok_cnt,
    output logic [15:0]         stat_tmo_cnt,
    output logic [15:0]         stat_ill_cnt
`endif
);

    localparam int TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [TMO_W-1:0]   c_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] c_DRAIN_LD  = DRAIN_W'(DRAIN_CYCLES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    req_state_e            r_state;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic                  r_alu_start;
    logic [OP_W-1:0]       r_alu_op;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic [RESULT_W-1:0]   r_rsp_result;
    status_e               r_rsp_status;

    req_state_e            w_state_nxt;
    logic [TMO_W-1:0]      w_tmo_nxt;
    logic [DRAIN_W-1:0]    w_drain_nxt;
    logic                  w_alu_start_nxt;
    logic [OP_W-1:0]       w_alu_op_nxt;
    logic [DATA_W-1:0]     w_alu_a_nxt;
    logic [DATA_W-1:0]     w_alu_b_nxt;
    logic [RESULT_W-1:0]   w_rsp_result_nxt;
    status_e               w_rsp_status_nxt;
    logic                  w_cmd_ready;
    logic                  w_accept;

    // The drain window keeps cmd_ready low after start falls so that late
    // done pulses from the ALU cannot be mistaken for the next command's.
    assign w_cmd_ready = (r_state == IDLE) && (r_drain_cnt == '0);
    assign w_accept    = cmd_valid && w_cmd_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_tmo_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_alu_start  <= 1'b0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_result <= '0;
            r_rsp_status <= OK;
        end else begin
            r_state      <= w_state_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_alu_start  <= w_alu_start_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_status <= w_rsp_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tmo_nxt        = r_tmo_cnt;
        w_drain_nxt      = (r_drain_cnt != '0) ? (r_drain_cnt - 1'b1) : '0;
        w_alu_start_nxt  = r_alu_start;
        w_alu_op_nxt     = r_alu_op;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_status_nxt = r_rsp_status;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (is_alu_op(cmd_op)) begin
                        // ALU operands stay on the ports until the next
                        // accept; the ALU result mux keys on alu_op.
                        w_alu_op_nxt    = cmd_op;
                        w_alu_a_nxt     = cmd_a;
                        w_alu_b_nxt     = cmd_b;
                        w_alu_start_nxt = 1'b1;
                        w_tmo_nxt       = '0;
                        w_state_nxt     = BUSY;
                    end else begin
                        w_rsp_result_nxt = '0;
                        w_rsp_status_nxt = (cmd_op == NO_OP) ? OK : ILLEGAL;
                        w_state_nxt      = RESP;
                    end
                end
            end

            BUSY: begin
                // done is checked first so a done on the expiry cycle wins.
                if (alu_done) begin
                    w_rsp_result_nxt = alu_result;
                    w_rsp_status_nxt = OK;
                    w_alu_start_nxt  = 1'b0;
                    w_drain_nxt      = c_DRAIN_LD;
                    w_state_nxt      = RESP;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_rsp_result_nxt = '0;
                    w_rsp_status_nxt = TIMEOUT;
                    w_alu_start_nxt  = 1'b0;
                    w_drain_nxt      = c_DRAIN_LD;
                    w_state_nxt      = RESP;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_alu_start_nxt = 1'b0;
            end
        endcase
    end

    assign cmd_ready  = w_cmd_ready;
    assign alu_start  = r_alu_start;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_status = r_rsp_status;

`ifdef TINYALU_REQ_STATS_EN
    logic w_rsp_enter;

    assign w_rsp_enter = (r_state != RESP) && (w_state_nxt == RESP);

    tinyalu_req_stats u_stats (
        .clk          (clk),
        .reset_n      (reset_n),
        .rsp_enter    (w_rsp_enter),
        .rsp_status   (w_rsp_status_nxt),
        .stat_ok_cnt  (stat_ok_cnt),
        .stat_tmo_cnt (stat_tmo_cnt),
        .stat_ill_cnt (stat_ill_cnt)
    );
`else
    // Statistics counters not built in this configuration.
`endif

endmodule : tinyalu_requester
`default_nettype wire
